// File: rtl/vic_irq_responder_pkg.sv
// Shared types and defaults for the vectored interrupt responder.
// Optional nesting is enabled by defining IRQ_NEST_EN.
package vic_pkg;

  localparam int unsigned IRQ_ADDR_W          = 5;
  localparam int unsigned NUM_IRQ             = 31;
  localparam logic [31:0] DEF_VEC_BASE        = 32'h0000_0100;
  localparam int unsigned DEF_VEC_STRIDE_LOG2 = 2;

  typedef logic [IRQ_ADDR_W-1:0] irq_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_VECTOR,
    ST_SERVICE,
    ST_RETURN
  } vic_state_e;

endpackage

// File: rtl/vic_irq_responder_if.sv
// Handshake bundle between controller/CPU (master) and the interrupt responder (slave).
// Signal names keep the responder's original port names.
interface vic_irq_responder_if #(
  parameter int unsigned PC_W = 32
);
  import vic_pkg::*;

  logic            i_irq;
  irq_addr_t       i_irq_addr;
  logic            i_en;
  logic            i_stall;
  logic [PC_W-1:0] i_pc;
  logic            i_reti;
  logic            o_in_service;
  logic            o_flush;
  logic            o_pc_load;
  logic [PC_W-1:0] o_pc_next;
  irq_addr_t       o_cur_irq;

  modport slave (
    input  i_irq, i_irq_addr, i_en, i_stall, i_pc, i_reti,
    output o_in_service, o_flush, o_pc_load, o_pc_next, o_cur_irq
  );

  modport master (
    output i_irq, i_irq_addr, i_en, i_stall, i_pc, i_reti,
    input  o_in_service, o_flush, o_pc_load, o_pc_next, o_cur_irq
  );

endinterface

// File: rtl/vic_irq_responder_irq_pc_stack.sv
// LIFO of interrupted {PC, source} contexts for nested interrupts.
// Only present when IRQ_NEST_EN is defined.
`ifdef IRQ_NEST_EN
module irq_pc_stack
  import vic_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_pc,
  input  irq_addr_t       i_addr,
  output logic [PC_W-1:0] o_pc,
  output irq_addr_t       o_addr,
  output logic            o_full,
  output logic            o_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] r_pc   [DEPTH];
  irq_addr_t       r_addr [DEPTH];
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   w_top;
  logic [IW-1:0]   w_wr;

  assign w_top   = IW'(r_cnt - 1'b1);
  assign w_wr    = IW'(r_cnt);
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_pc    = o_empty ? '0 : r_pc[w_top];
  assign o_addr  = o_empty ? '0 : r_addr[w_top];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_addr[i] <= '0;
      end
    end else if (i_push && !o_full) begin
      r_pc[w_wr]   <= i_pc;
      r_addr[w_wr] <= i_addr;
      r_cnt        <= r_cnt + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
`endif

// File: rtl/vic_irq_responder.sv
// CPU-side vectored interrupt responder: latch request, flush, vector, service, return.
// Define IRQ_NEST_EN to allow nested interrupts through a saved-context stack.
module vic_irq_responder
  import vic_pkg::*;
#(
  parameter int unsigned     PC_W            = 32,
  parameter logic [PC_W-1:0] VEC_BASE        = PC_W'(DEF_VEC_BASE),
  parameter int unsigned     VEC_STRIDE_LOG2 = DEF_VEC_STRIDE_LOG2,
  parameter int unsigned     NEST_DEPTH      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  vic_irq_responder_if.slave   io_vic
);

  vic_state_e      r_state;
  logic            r_pend;
  irq_addr_t       r_paddr;
  irq_addr_t       r_take;
  logic [PC_W-1:0] r_saved_pc;
  logic            r_in_service;
  logic            r_flush;
  logic            r_pc_load;
  logic [PC_W-1:0] r_pc_next;
  irq_addr_t       r_cur;

  logic            w_req;
  irq_addr_t       w_req_addr;
  logic            w_go;
  logic [PC_W-1:0] w_vec;

  // A request arriving this edge counts as pending immediately, so IDLE can take it at once.
  assign w_req      = r_pend | io_vic.i_irq;
  assign w_req_addr = r_pend ? r_paddr : io_vic.i_irq_addr;
  assign w_go       = w_req & io_vic.i_en & ~io_vic.i_stall;
  assign w_vec      = VEC_BASE + (PC_W'(r_take) << VEC_STRIDE_LOG2);

  a_nest_depth: assert property (@(posedge i_clk) NEST_DEPTH > 0);

`ifdef IRQ_NEST_EN
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [PC_W-1:0] w_top_pc;
  irq_addr_t       w_top_addr;
  logic            r_ret_nested;

  assign w_push = (r_state == ST_SERVICE) & ~io_vic.i_reti & w_go & ~w_full;
  assign w_pop  = (r_state == ST_SERVICE) & io_vic.i_reti & ~w_empty;

  irq_pc_stack #(
    .PC_W  (PC_W),
    .DEPTH (NEST_DEPTH)
  ) u_stack (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_pc    (r_saved_pc),
    .i_addr  (r_cur),
    .o_pc    (w_top_pc),
    .o_addr  (w_top_addr),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_pend       <= 1'b0;
      r_paddr      <= '0;
      r_take       <= '0;
      r_saved_pc   <= '0;
      r_in_service <= 1'b0;
      r_flush      <= 1'b0;
      r_pc_load    <= 1'b0;
      r_pc_next    <= '0;
      r_cur        <= '0;
`ifdef IRQ_NEST_EN
      r_ret_nested <= 1'b0;
`endif
    end else begin
      r_flush   <= 1'b0;
      r_pc_load <= 1'b0;
      r_pc_next <= '0;

      if (io_vic.i_irq && !r_pend) begin
        r_pend  <= 1'b1;
        r_paddr <= io_vic.i_irq_addr;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state <= ST_FLUSH;
            r_flush <= 1'b1;
            r_pend  <= 1'b0;
            r_take  <= w_req_addr;
          end
        end
        ST_FLUSH: begin
          r_state      <= ST_VECTOR;
          r_saved_pc   <= io_vic.i_pc;
          r_cur        <= r_take;
          r_pc_load    <= 1'b1;
          r_pc_next    <= w_vec;
          r_in_service <= 1'b1;
        end
        ST_VECTOR: begin
          r_state <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (io_vic.i_reti) begin
            r_state   <= ST_RETURN;
            r_pc_load <= 1'b1;
            r_pc_next <= r_saved_pc;
`ifdef IRQ_NEST_EN
            // Popping here puts the outer context back in place by the time RETURN ends.
            r_ret_nested <= w_pop;
            if (w_pop) begin
              r_saved_pc <= w_top_pc;
              r_cur      <= w_top_addr;
            end else begin
              r_in_service <= 1'b0;
            end
`else
            r_in_service <= 1'b0;
`endif
          end
`ifdef IRQ_NEST_EN
          else if (w_push) begin
            r_state <= ST_FLUSH;
            r_flush <= 1'b1;
            r_pend  <= 1'b0;
            r_take  <= w_req_addr;
          end
`endif
        end
        ST_RETURN: begin
`ifdef IRQ_NEST_EN
          r_state <= r_ret_nested ? ST_SERVICE : ST_IDLE;
`else
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_vic.o_in_service = r_in_service;
  assign io_vic.o_flush      = r_flush;
  assign io_vic.o_pc_load    = r_pc_load;
  assign io_vic.o_pc_next    = r_pc_next;
  assign io_vic.o_cur_irq    = r_cur;

endmodule

// File: tb/tb_vic_irq_responder.sv
// Self-checking bench for vic_irq_responder: context-list model checked every cycle
// plus directed literal checks. Nesting scenarios run when IRQ_NEST_EN is defined.
module tb_vic_irq_responder;

  localparam int unsigned NEST_DEPTH = 4;
`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vic_irq_responder_if #(.PC_W(32)) vic_if ();

  vic_irq_responder #(
    .PC_W            (32),
    .VEC_BASE        (32'h0000_0100),
    .VEC_STRIDE_LOG2 (2),
    .NEST_DEPTH      (NEST_DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_vic (vic_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Model: a list of interrupted contexts (one per active ISR) plus a pending slot.
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  irq;
  } ctx_t;

  ctx_t        ctx[$];
  bit          m_pend;
  logic [4:0]  m_paddr;
  logic [4:0]  m_take;
  int          ph;       // 0 steady, 1 just flushed, 2 just vectored, 3 just returned
  bit          e_flush, e_load, e_insvc;
  logic [31:0] e_next;
  logic [4:0]  e_cur;
  bit          started = 1'b0;

  always @(posedge clk) begin
    bit         req, go, take;
    logic [4:0] raddr;
    ctx_t       c;
    started = 1'b1;
    if (rst) begin
      ctx.delete();
      m_pend = 0; m_paddr = '0; m_take = '0; ph = 0;
      e_flush = 0; e_load = 0; e_insvc = 0; e_next = '0; e_cur = '0;
    end else begin
      req   = m_pend | vic_if.i_irq;
      raddr = m_pend ? m_paddr : vic_if.i_irq_addr;
      go    = req & vic_if.i_en & ~vic_if.i_stall;
      take  = 0;
      if (vic_if.i_irq && !m_pend) begin
        m_pend = 1; m_paddr = vic_if.i_irq_addr;
      end
      e_flush = 0; e_load = 0; e_next = '0;
      case (ph)
        0: begin
          if (ctx.size() == 0) take = go;
          else if (vic_if.i_reti) begin
            c = ctx.pop_back();
            e_load = 1; e_next = c.pc;
            if (ctx.size() > 0) e_cur = c.irq;
            e_insvc = (ctx.size() > 0);
            ph = 3;
          end else if (NEST && go && ctx.size() <= NEST_DEPTH) take = 1;
        end
        1: begin
          ctx.push_back('{pc: vic_if.i_pc, irq: e_cur});
          e_cur = m_take;
          e_load = 1;
          e_next = 32'h100 + 32'(m_take) * 4;
          e_insvc = 1;
          ph = 2;
        end
        default: ph = 0;
      endcase
      if (take) begin
        m_take = raddr; m_pend = 0; e_flush = 1; ph = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_flush",   32'(vic_if.o_flush),      32'(e_flush));
      chk("m_pc_load", 32'(vic_if.o_pc_load),    32'(e_load));
      chk("m_pc_next", vic_if.o_pc_next,         e_next);
      chk("m_in_svc",  32'(vic_if.o_in_service), 32'(e_insvc));
      chk("m_cur_irq", 32'(vic_if.o_cur_irq),    32'(e_cur));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_irq(input logic [4:0] a);
    vic_if.i_irq = 1; vic_if.i_irq_addr = a;
    cyc();
    vic_if.i_irq = 0;
  endtask

  task automatic pulse_reti();
    vic_if.i_reti = 1;
    cyc();
    vic_if.i_reti = 0;
  endtask

  initial begin
    vic_if.i_irq = 0; vic_if.i_irq_addr = '0; vic_if.i_en = 1;
    vic_if.i_stall = 0; vic_if.i_pc = 32'h40; vic_if.i_reti = 0;
    cyc(2);
    chk("rst_in_svc", 32'(vic_if.o_in_service), 32'd0);
    chk("rst_load",   32'(vic_if.o_pc_load),    32'd0);
    chk("rst_cur",    32'(vic_if.o_cur_irq),    32'd0);
    rst = 0;
    cyc();

    // Basic take, addr 5
    pulse_irq(5'd5);
    chk("take_flush", 32'(vic_if.o_flush), 32'd1);
    cyc();
    chk("take_load",  32'(vic_if.o_pc_load), 32'd1);
    chk("take_next",  vic_if.o_pc_next, 32'h114);
    chk("take_svc",   32'(vic_if.o_in_service), 32'd1);
    chk("take_cur",   32'(vic_if.o_cur_irq), 32'd5);
    vic_if.i_pc = 32'h200;
    cyc(3);
    pulse_reti();
    chk("ret_load", 32'(vic_if.o_pc_load), 32'd1);
    chk("ret_next", vic_if.o_pc_next, 32'h40);
    chk("ret_svc",  32'(vic_if.o_in_service), 32'd0);
    cyc();
    chk("idle_load", 32'(vic_if.o_pc_load), 32'd0);

    // i_reti while idle is ignored
    pulse_reti();
    chk("reti_idle", 32'(vic_if.o_pc_load), 32'd0);

    // Stall then disable; first request (9) wins over the later one (12)
    vic_if.i_stall = 1;
    pulse_irq(5'd9);
    pulse_irq(5'd12);
    cyc();
    chk("stall_hold", 32'(vic_if.o_flush), 32'd0);
    vic_if.i_stall = 0; vic_if.i_en = 0;
    cyc(2);
    chk("dis_hold", 32'(vic_if.o_flush), 32'd0);
    vic_if.i_en = 1; vic_if.i_pc = 32'h300;
    cyc();
    chk("late_flush", 32'(vic_if.o_flush), 32'd1);
    cyc();
    chk("late_next", vic_if.o_pc_next, 32'h124);
    chk("late_cur",  32'(vic_if.o_cur_irq), 32'd9);
    cyc(2);

    // Return and a new request (addr 2) on the same edge
    vic_if.i_reti = 1; vic_if.i_irq = 1; vic_if.i_irq_addr = 5'd2;
    cyc();
    vic_if.i_reti = 0; vic_if.i_irq = 0;
    chk("sim_ret_next", vic_if.o_pc_next, 32'h300);
    chk("sim_ret_svc",  32'(vic_if.o_in_service), 32'd0);
    cyc();
    chk("sim_gap", 32'(vic_if.o_flush), 32'd0);
    cyc();
    chk("sim_flush", 32'(vic_if.o_flush), 32'd1);
    cyc();
    chk("sim_next", vic_if.o_pc_next, 32'h108);
    cyc(2);
    pulse_reti();
    cyc(2);

    // Highest source number
    pulse_irq(5'd31);
    cyc();
    chk("max_next", vic_if.o_pc_next, 32'h17C);
    cyc(2);
    pulse_reti();
    cyc(2);

    // Reset during VECTOR, with a request on the reset edge
    pulse_irq(5'd7);
    cyc();
    rst = 1; vic_if.i_irq = 1; vic_if.i_irq_addr = 5'd6;
    cyc();
    rst = 0; vic_if.i_irq = 0;
    chk("rv_load", 32'(vic_if.o_pc_load), 32'd0);
    chk("rv_svc",  32'(vic_if.o_in_service), 32'd0);
    chk("rv_cur",  32'(vic_if.o_cur_irq), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rv_quiet_flush", 32'(vic_if.o_flush), 32'd0);
      chk("rv_quiet_load",  32'(vic_if.o_pc_load), 32'd0);
    end

    // Reset during SERVICE
    pulse_irq(5'd4);
    cyc(3);
    rst = 1;
    cyc();
    rst = 0;
    chk("rs_svc",  32'(vic_if.o_in_service), 32'd0);
    chk("rs_next", vic_if.o_pc_next, 32'd0);
    cyc(3);
    chk("rs_quiet", 32'(vic_if.o_pc_load), 32'd0);

`ifdef IRQ_NEST_EN
    // Addr 3 taken, then addr 1 nested
    vic_if.i_pc = 32'h40;
    pulse_irq(5'd3);
    cyc();
    chk("n_outer_next", vic_if.o_pc_next, 32'h10C);
    vic_if.i_pc = 32'h500;
    cyc();
    pulse_irq(5'd1);
    chk("n_flush_svc", 32'(vic_if.o_in_service), 32'd1);
    cyc();
    chk("n_inner_next", vic_if.o_pc_next, 32'h104);
    vic_if.i_pc = 32'h600;
    cyc();
    pulse_reti();
    chk("n_ret1_next", vic_if.o_pc_next, 32'h500);
    chk("n_ret1_svc",  32'(vic_if.o_in_service), 32'd1);
    chk("n_ret1_cur",  32'(vic_if.o_cur_irq), 32'd3);
    cyc();
    pulse_reti();
    chk("n_ret2_next", vic_if.o_pc_next, 32'h40);
    chk("n_ret2_svc",  32'(vic_if.o_in_service), 32'd0);
    cyc();

    // Fill: outer ISR, then NEST_DEPTH + 1 nested requests; the last one waits
    pulse_irq(5'd10);
    cyc(2);
    for (int k = 0; k <= NEST_DEPTH; k++) begin
      vic_if.i_pc = 32'h1000 + 32'(k) * 32'h10;
      pulse_irq(5'(11 + k));
      if (k == NEST_DEPTH) chk("n_full_hold", 32'(vic_if.o_flush), 32'd0);
      cyc(2);
    end
    for (int i = 0; i < 12; i++) begin
      pulse_reti();
      cyc(3);
    end
    chk("n_unwound", 32'(vic_if.o_in_service), 32'd0);
`endif

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
